// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared CPU definitions for the MEM-stage data-memory access controller
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int TIMEOUT_CYC_DEF = 255;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access FSM with stall, timeout and sticky error
//   clk, rst_n                       : clock, async active-low reset
//   MemReadM/MemWriteM/ALUOutM/WriteDataM : MEM-stage access request
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_ready/mem_rdata               : memory completion strobe and read data
//   ReadDataM                         : captured load data for MEM/WB
//   StallPipe                         : freezes the pipeline while an access is in flight
//   MemErr                            : sticky error (illegal access or timeout)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallPipe,
  output logic        MemErr
);
  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic       w_access, w_misal, w_legal, w_err, w_to;
  assign w_access = MemReadM ^ MemWriteM;
  assign w_misal  = |ALUOutM[1:0];
  assign w_legal  = w_access & ~w_misal;
  assign w_err    = (MemReadM & MemWriteM) | (w_access & w_misal);
  assign w_to     = r_cnt == 8'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // StallPipe is gated by rst_n so a reset mid-access releases the pipeline at once
  always_comb begin
    w_next    = IDLE;
    StallPipe = 1'b0;
    w_next    = (r_state == IDLE) ? (w_legal ? BUSY : IDLE) :
                (r_state == BUSY) ? ((mem_ready || w_to) ? DONE : BUSY) : IDLE;
    StallPipe = rst_n && ((r_state == IDLE && w_legal) || r_state == BUSY);
  end
  // mem_ready wins over the timeout because it is tested first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      MemErr    <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == IDLE) begin
      if (w_err) MemErr <= 1'b1;
      if (w_legal) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= ALUOutM;
        mem_wdata <= WriteDataM;
        r_cnt     <= '0;
      end
    end else if (r_state == BUSY) begin
      if (mem_ready) begin
        mem_req <= 1'b0;
        if (!mem_we) ReadDataM <= mem_rdata;
      end else if (w_to) begin
        mem_req   <= 1'b0;
        MemErr    <= 1'b1;
        ReadDataM <= '0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum number of cycles spent waiting for mem_ready.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have ports MemReadM and MemWriteM, input, 1 bit each: the MEM-stage access request.
REQ-005 SHALL have port ALUOutM, input, 32 bits: the byte address. SHALL have port WriteDataM, input, 32 bits: the store data.
REQ-006 SHALL have ports mem_req, mem_we, mem_addr[31:0] and mem_wdata[31:0], all outputs: the registered data-memory request.
REQ-007 SHALL have port mem_ready, input, 1 bit: the memory completion strobe. SHALL have port mem_rdata, input, 32 bits: the memory read data.
REQ-008 SHALL have port ReadDataM, output, 32 bits: the captured load data, feeding the MEM/WB register.
REQ-009 SHALL have port StallPipe, output, 1 bit: holds the PC and the IF/ID, ID/EX and EX/MEM registers, and inserts a bubble into MEM/WB.
REQ-010 SHALL have port MemErr, output, 1 bit: sticky error flag.

Function
REQ-011 SHALL define an access as MemReadM XOR MemWriteM. If both are asserted, the block SHALL set MemErr and SHALL issue no request.
REQ-012 SHALL define an access as misaligned when ALUOutM[1:0] != 0. A misaligned access SHALL set MemErr, SHALL issue no request and SHALL NOT stall.
REQ-013 SHALL implement a 3-state FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE, a legal access SHALL cause the block to:
- register mem_req=1;
- register mem_we=MemWriteM;
- register mem_addr=ALUOutM;
- register mem_wdata=WriteDataM;
- clear the wait counter;
- go to BUSY.
REQ-015 In BUSY, mem_req SHALL stay at 1 and the address, data and we outputs SHALL stay stable until mem_ready is sampled high.
REQ-016 In BUSY, mem_ready=1 SHALL cause the block to:
- capture mem_rdata into ReadDataM (read only; a write leaves ReadDataM unchanged);
- drop mem_req;
- go to DONE.
REQ-017 In BUSY, if the wait counter reaches TIMEOUT_CYC-1 without mem_ready, the block SHALL:
- set MemErr;
- load ReadDataM=0;
- drop mem_req;
- go to DONE.
REQ-018 If mem_ready arrives in the same cycle as the timeout, mem_ready SHALL take precedence (normal completion, no error).
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE. During that cycle the pipeline advances.
REQ-020 StallPipe SHALL equal (IDLE AND legal access) OR BUSY. It is combinational, so the stall applies in the same cycle the access appears.
REQ-021 Minimum latency SHALL be: access seen in IDLE at cycle N, mem_req high from N+1, mem_ready at N+1, DONE at N+2, StallPipe low at N+2.
REQ-022 A mem_ready pulse while in IDLE or DONE SHALL be ignored.
REQ-023 MemErr SHALL remain set until reset.

Reset
REQ-024 While rst_n=0, the block SHALL set:
- the state to IDLE;
- mem_req, mem_we and MemErr to 0;
- mem_addr, mem_wdata and ReadDataM to 0;
- the wait counter to 0.
REQ-025 Assertion of rst_n SHALL take effect immediately, independent of clk, including mid-BUSY; the outstanding transaction SHALL be abandoned.
REQ-026 Deassertion SHALL be synchronised externally. On the first clk edge after release, the block SHALL be in IDLE.

Structure
REQ-027 The FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and TIMEOUT_CYC default SHALL live in the shared CPU definitions package.
REQ-028 The block SHALL be a single module with no sub-modules. The wait counter SHALL be 8 bits wide, saturating.

Verification
REQ-029 The bench SHALL cover a load: rst_n released, MemReadM=1, ALUOutM=0x10, mem_ready=1 one cycle after mem_req with mem_rdata=0xCAFEF00D. Required response: StallPipe high 2 cycles, ReadDataM=0xCAFEF00D in DONE, MemErr=0.
REQ-030 The bench SHALL cover a store with wait: MemWriteM=1, ALUOutM=0x20, WriteDataM=0x12345678, mem_ready delayed 5 cycles. Required response: mem_we=1, mem_wdata stable for 5 cycles, StallPipe high 6 cycles, ReadDataM unchanged.
REQ-031 The bench SHALL cover a misaligned access: MemReadM=1, ALUOutM=0x13. Required response: mem_req never rises, StallPipe=0, MemErr=1, and MemErr stays 1 after subsequent legal accesses.
REQ-032 The bench SHALL cover a timeout with TIMEOUT_CYC=4 and mem_ready held low. Required response: MemErr=1 and ReadDataM=0 after 4 BUSY cycles, then DONE, then IDLE.
REQ-033 The bench SHALL cover reset mid-transaction: rst_n pulled low between clk edges while in BUSY. Required response: mem_req=0 and StallPipe=0 immediately, state IDLE, all outputs zero.
REQ-034 The bench SHALL cover a race: mem_ready coincides with the timeout cycle. Required response: normal completion, MemErr=0, ReadDataM=mem_rdata.
